gpio_read_port: RTL and testbench

GPIO_READ_PORT -- requirements
Module: gpio_read_port

---
 rtl/gpio_read_port.sv | 114 +++++++++++
 tb/tb_gpio_read_port.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_read_port.sv
// GPIO read port: synchronised pin levels, sticky change events with read-clear, and an interrupt line.
// Optional per-bit debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_read_port #(
    parameter logic [31:0] DATA_ADDR       = 32'h0000ABCE,
    parameter logic [31:0] STAT_ADDR       = 32'h0000ABCF,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] gpio_in,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        irq
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be in 1..15");
    end

    logic [31:0] r_sync1;
    logic [31:0] r_sync2;
    logic [31:0] w_level;
    logic [31:0] r_prev;
    logic [31:0] r_event;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_irq;

    logic        w_data_hit;
    logic        w_stat_hit;
    logic [31:0] w_edge;
    logic [31:0] w_clr;
    logic [31:0] w_event_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  r_cnt [32];
    logic [31:0] r_level;

    // Counter runs only while the synchronised pin disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    always_comb begin
        w_data_hit  = rd_en && (rd_addr == DATA_ADDR);
        w_stat_hit  = rd_en && (rd_addr == STAT_ADDR);
        w_edge      = w_level ^ r_prev;
        w_clr       = w_stat_hit ? r_event : '0;
        // New edges are OR'd in after the clear so a same-cycle edge survives.
        w_event_nxt = (r_event & ~w_clr) | w_edge;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_event    <= '0;
            r_irq      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_prev     <= w_level;
            r_event    <= w_event_nxt;
            r_irq      <= |w_event_nxt;
            r_rd_valid <= w_data_hit || w_stat_hit;
            if (w_data_hit) begin
                r_rd_data <= w_level;
            end else if (w_stat_hit) begin
                r_rd_data <= r_event;
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_read_port.sv
// Directed self-checking bench for gpio_read_port; define GPIO_DEBOUNCE_EN to also exercise the filter.
module tb_gpio_read_port;

    localparam logic [31:0] DATA_A = 32'h0000ABCE;
    localparam logic [31:0] STAT_A = 32'h0000ABCF;
    localparam logic [31:0] MISS_A = 32'h0000ABCD;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] gpio_in = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;

    int errors = 0;
    int checks = 0;

    gpio_read_port #(
        .DATA_ADDR(DATA_A),
        .STAT_ADDR(STAT_A),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gpio_in(gpio_in),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic wait_irq(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (irq === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: irq stayed %b, expected 1 within 40 cycles", name, irq);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        gpio_in = '0;
        rd_en   = 1'b1;
        rd_addr = DATA_A;
        repeat (3) tick();
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, 32'h0); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        rd_en = 1'b0;
        do_read(DATA_A);
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b expected 1", rd_valid); end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL post_reset_data: got %h expected %h", rd_data, 32'h0); end
    endtask

    task automatic test_level();
        gpio_in = 32'hA5A5_0F0F;
        repeat (10) tick();
        do_read(DATA_A);
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL level_valid: got %b expected 1", rd_valid); end
        checks++;
        if (rd_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL level_data: got %h expected %h", rd_data, 32'hA5A5_0F0F); end
        do_read(STAT_A);
        checks++;
        if (rd_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL level_events: got %h expected %h", rd_data, 32'hA5A5_0F0F); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL level_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_event_clear();
        gpio_in = '0;
        repeat (10) tick();
        do_read(STAT_A);
        checks++;
        if (rd_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL fall_events: got %h expected %h", rd_data, 32'hA5A5_0F0F); end
        gpio_in = 32'h0000_0008;
        wait_irq("event_irq_rise");
        do_read(STAT_A);
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL event_valid: got %b expected 1", rd_valid); end
        checks++;
        if (rd_data !== 32'h0000_0008) begin errors++; $display("FAIL event_data: got %h expected %h", rd_data, 32'h8); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL event_irq_clear: got %b expected 0", irq); end
        do_read(STAT_A);
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL event_reread: got %h expected %h", rd_data, 32'h0); end
    endtask

    task automatic test_set_wins();
        gpio_in = '0;
        wait_irq("collide_irq_rise");
        gpio_in = 32'h0000_0080;
        repeat (LAT) tick();
        do_read(STAT_A);
        checks++;
        if (rd_data !== 32'h0000_0008) begin errors++; $display("FAIL collide_data: got %h expected %h", rd_data, 32'h8); end
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL collide_valid: got %b expected 1", rd_valid); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", irq); end
        do_read(STAT_A);
        checks++;
        if (rd_data !== 32'h0000_0080) begin errors++; $display("FAIL collide_remaining: got %h expected %h", rd_data, 32'h80); end
    endtask

    task automatic test_back_to_back();
        rd_en   = 1'b1;
        rd_addr = DATA_A;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0080) begin
            errors++; $display("FAIL b2b_data: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h80);
        end
        rd_addr = MISS_A;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL b2b_miss: got v=%b d=%h expected v=0 d=%h", rd_valid, rd_data, 32'h0);
        end
        rd_addr = STAT_A;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            errors++; $display("FAIL b2b_stat: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h0);
        end
        rd_en   = 1'b0;
        rd_addr = '0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL b2b_idle: got v=%b d=%h expected v=0 d=%h", rd_valid, rd_data, 32'h0);
        end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        gpio_in = 32'h0000_0081;
        repeat (2) tick();
        gpio_in = 32'h0000_0080;
        repeat (12) tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
        do_read(DATA_A);
        checks++;
        if (rd_data !== 32'h0000_0080) begin errors++; $display("FAIL glitch_level: got %h expected %h", rd_data, 32'h80); end
        // Response after edge j reflects the level registered at edge j-1; level flips at edge 6.
        gpio_in = 32'h0000_0081;
        rd_en   = 1'b1;
        rd_addr = DATA_A;
        for (int j = 1; j <= 7; j++) begin
            tick();
            checks++;
            if (rd_data[0] !== (j >= 7)) begin
                errors++; $display("FAIL deb_level_%0d: got %b expected %b", j, rd_data[0], (j >= 7));
            end
            checks++;
            if (irq !== (j >= 7)) begin
                errors++; $display("FAIL deb_irq_%0d: got %b expected %b", j, irq, (j >= 7));
            end
        end
        rd_en   = 1'b0;
        rd_addr = '0;
        do_read(STAT_A);
        checks++;
        if (rd_data !== 32'h0000_0001) begin errors++; $display("FAIL deb_event: got %h expected %h", rd_data, 32'h1); end
    endtask
`endif

    initial begin
        test_reset();
        test_level();
        test_event_clear();
        test_set_wins();
        test_back_to_back();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
